// File: rtl/mitm_controller.sv
// mitm_controller: sequencer for the UART man-in-the-middle datapath.
// Received bytes from if0/if1 are transformed according to the current mode
// and queued toward the opposite interface's transmitter. This block also owns
// the mode register and the communication-session tracker.
// Optional frame counters are enabled with the macro MITM_FRAME_COUNT_EN.

module mitm_tx_path #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         tx_busy,
   output logic [W-1:0] tx_data,
   output logic         tx_start,
   output logic         overflow,
   output logic         empty,
   output logic         idle
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_WAIT_BUSY,
      TX_WAIT_DONE
   } tx_state_e;

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         ovf_q, ovf_d;
   logic         full;
   tx_state_e    state_q, state_d;
   logic [1:0]   wait_q, wait_d;
   logic [W-1:0] tx_data_q, tx_data_d;
   logic         tx_start_q, tx_start_d;

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign overflow = ovf_q;
   assign idle     = (state_q == TX_IDLE);

   // Enqueue side: store the byte, or drop it and raise the sticky overflow flag when full.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      ovf_d = ovf_q;
      if (push) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + 1'b1;
         end
      end
   end

   // Transmit handshake: pop one byte, pulse start, then follow busy (with a short timeout if busy never shows).
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      wait_d     = wait_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (!empty && !tx_busy) begin
               tx_data_d  = mem_q[rd_q[AW-1:0]];
               rd_d       = rd_q + 1'b1;
               tx_start_d = 1'b1;
               wait_d     = 2'd0;
               state_d    = TX_WAIT_BUSY;
            end
         end
         TX_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = TX_WAIT_DONE;
            end else if (wait_q == 2'd3) begin
               state_d = TX_IDLE;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         TX_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // State registers for the queue and the transmit handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q       <= '0;
         rd_q       <= '0;
         ovf_q      <= 1'b0;
         state_q    <= TX_IDLE;
         wait_q     <= 2'd0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         wait_q     <= wait_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

endmodule

module mitm_controller #(
   parameter int                       NUM_DATA_BITS       = 8,
   parameter int                       MODE_WIDTH          = 4,
   parameter logic [NUM_DATA_BITS-1:0] SUB_VALUE           = 8'hA5,
   parameter int                       FIFO_DEPTH          = 2,
   parameter int                       IDLE_TIMEOUT_CYCLES = 1250
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     mode_next,
   output logic [MODE_WIDTH-1:0]    mode_leds,
   output logic                     comm_active,
   input  logic [NUM_DATA_BITS-1:0] if0_rx_data,
   input  logic                     if0_rx_valid,
   input  logic [NUM_DATA_BITS-1:0] if1_rx_data,
   input  logic                     if1_rx_valid,
   output logic [NUM_DATA_BITS-1:0] if0_tx_data,
   output logic                     if0_tx_start,
   input  logic                     if0_tx_busy,
   output logic [NUM_DATA_BITS-1:0] if1_tx_data,
   output logic                     if1_tx_start,
   input  logic                     if1_tx_busy,
   output logic [1:0]               overflow,
   output logic [15:0]              frame_cnt0,
   output logic [15:0]              frame_cnt1
);

   localparam int IDLE_CW = $clog2(IDLE_TIMEOUT_CYCLES);
   localparam logic [IDLE_CW-1:0] IDLE_LIMIT = IDLE_CW'(IDLE_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_FORWARD,
      MODE_SUB0_BLOCK1,
      MODE_SUB1_BLOCK0,
      MODE_ROT13
   } mode_e;

   mode_e                     mode_q, mode_d;
   logic                      pending_q, pending_d;
   logic                      comm_active_q, comm_active_d;
   logic [IDLE_CW-1:0]        idle_cnt_q, idle_cnt_d;
   logic                      any_rx;
   logic                      mode_step;
   logic                      all_quiet;
   logic                      push01, push10;
   logic [NUM_DATA_BITS-1:0]  push01_data, push10_data;
   logic                      empty01, empty10, idle01, idle10;
   logic                      ovf01, ovf10;

   function automatic logic [NUM_DATA_BITS-1:0] rot13(input logic [NUM_DATA_BITS-1:0] b);
      logic [NUM_DATA_BITS-1:0] r;
      r = b;
      if ((b >= NUM_DATA_BITS'(8'h41) && b <= NUM_DATA_BITS'(8'h4D)) ||
          (b >= NUM_DATA_BITS'(8'h61) && b <= NUM_DATA_BITS'(8'h6D))) begin
         r = b + NUM_DATA_BITS'(13);
      end else if ((b >= NUM_DATA_BITS'(8'h4E) && b <= NUM_DATA_BITS'(8'h5A)) ||
                   (b >= NUM_DATA_BITS'(8'h6E) && b <= NUM_DATA_BITS'(8'h7A))) begin
         r = b - NUM_DATA_BITS'(13);
      end
      return r;
   endfunction

   assign any_rx      = if0_rx_valid | if1_rx_valid;
   assign mode_step   = (pending_q | mode_next) & ~comm_active_q & ~any_rx;
   assign all_quiet   = empty01 & empty10 & idle01 & idle10;
   assign mode_leds   = MODE_WIDTH'(1) << mode_q;
   assign comm_active = comm_active_q;
   assign overflow    = {ovf10, ovf01};

   // Apply the current mode to each received byte and decide whether it gets queued.
   always_comb begin
      push01      = if0_rx_valid;
      push10      = if1_rx_valid;
      push01_data = if0_rx_data;
      push10_data = if1_rx_data;
      case (mode_q)
         MODE_SUB0_BLOCK1: begin
            push01_data = SUB_VALUE;
            push10      = 1'b0;
         end
         MODE_SUB1_BLOCK0: begin
            push10_data = SUB_VALUE;
            push01      = 1'b0;
         end
         MODE_ROT13: begin
            push01_data = rot13(if0_rx_data);
            push10_data = rot13(if1_rx_data);
         end
         default: ;
      endcase
   end

   // Mode stepping is deferred until the session ends; extra pulses while pending collapse.
   always_comb begin
      mode_d    = mode_q;
      pending_d = pending_q | mode_next;
      if (mode_step) begin
         mode_d    = mode_e'(mode_q + 2'd1);
         pending_d = 1'b0;
      end
   end

   // Session tracker: any received byte re-arms it; it ends after the idle window once everything drained.
   always_comb begin
      comm_active_d = comm_active_q;
      idle_cnt_d    = idle_cnt_q;
      if (any_rx) begin
         comm_active_d = 1'b1;
         idle_cnt_d    = '0;
      end else if (comm_active_q) begin
         if (idle_cnt_q == IDLE_LIMIT) begin
            if (all_quiet) begin
               comm_active_d = 1'b0;
               idle_cnt_d    = '0;
            end
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   // Mode and session registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q        <= MODE_FORWARD;
         pending_q     <= 1'b0;
         comm_active_q <= 1'b0;
         idle_cnt_q    <= '0;
      end else begin
         mode_q        <= mode_d;
         pending_q     <= pending_d;
         comm_active_q <= comm_active_d;
         idle_cnt_q    <= idle_cnt_d;
      end
   end

   mitm_tx_path #(.W(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_path01 (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .push      (push01),
      .push_data (push01_data),
      .tx_busy   (if1_tx_busy),
      .tx_data   (if1_tx_data),
      .tx_start  (if1_tx_start),
      .overflow  (ovf01),
      .empty     (empty01),
      .idle      (idle01)
   );

   mitm_tx_path #(.W(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_path10 (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .push      (push10),
      .push_data (push10_data),
      .tx_busy   (if0_tx_busy),
      .tx_data   (if0_tx_data),
      .tx_start  (if0_tx_start),
      .overflow  (ovf10),
      .empty     (empty10),
      .idle      (idle10)
   );

`ifdef MITM_FRAME_COUNT_EN
   logic [15:0] frame_cnt0_q, frame_cnt0_d;
   logic [15:0] frame_cnt1_q, frame_cnt1_d;

   assign frame_cnt0 = frame_cnt0_q;
   assign frame_cnt1 = frame_cnt1_q;

   // Saturating per-direction frame counters, cleared whenever the mode changes.
   always_comb begin
      frame_cnt0_d = frame_cnt0_q;
      frame_cnt1_d = frame_cnt1_q;
      if (mode_step) begin
         frame_cnt0_d = '0;
         frame_cnt1_d = '0;
      end else begin
         if (if1_tx_start && frame_cnt0_q != 16'hFFFF) begin
            frame_cnt0_d = frame_cnt0_q + 16'd1;
         end
         if (if0_tx_start && frame_cnt1_q != 16'hFFFF) begin
            frame_cnt1_d = frame_cnt1_q + 16'd1;
         end
      end
   end

   // Frame counter registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_cnt0_q <= '0;
         frame_cnt1_q <= '0;
      end else begin
         frame_cnt0_q <= frame_cnt0_d;
         frame_cnt1_q <= frame_cnt1_d;
      end
   end
`else
   assign frame_cnt0 = 16'd0;
   assign frame_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mitm_controller.sv
// Directed testbench for mitm_controller: forwarding latency, session timeout,
// deferred mode stepping, all four modes, overflow and reset flush.
// Frame-count expectations follow the MITM_FRAME_COUNT_EN macro.

module tb_mitm_controller;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       mode_next;
   logic [3:0] mode_leds;
   logic       comm_active;
   logic [7:0] if0_rx_data, if1_rx_data;
   logic       if0_rx_valid, if1_rx_valid;
   logic [7:0] if0_tx_data, if1_tx_data;
   logic       if0_tx_start, if1_tx_start;
   logic       if0_tx_busy, if1_tx_busy;
   logic [1:0] overflow;
   logic [15:0] frame_cnt0, frame_cnt1;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;
   int t0;

   logic [7:0] txq0[$];
   logic [7:0] txq1[$];

`ifdef MITM_FRAME_COUNT_EN
   localparam int EXP_CNT = 2;
`else
   localparam int EXP_CNT = 0;
`endif

   mitm_controller dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .mode_next    (mode_next),
      .mode_leds    (mode_leds),
      .comm_active  (comm_active),
      .if0_rx_data  (if0_rx_data),
      .if0_rx_valid (if0_rx_valid),
      .if1_rx_data  (if1_rx_data),
      .if1_rx_valid (if1_rx_valid),
      .if0_tx_data  (if0_tx_data),
      .if0_tx_start (if0_tx_start),
      .if0_tx_busy  (if0_tx_busy),
      .if1_tx_data  (if1_tx_data),
      .if1_tx_start (if1_tx_start),
      .if1_tx_busy  (if1_tx_busy),
      .overflow     (overflow),
      .frame_cnt0   (frame_cnt0),
      .frame_cnt1   (frame_cnt1)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Record every byte launched on each transmitter, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (if1_tx_start) txq1.push_back(if1_tx_data);
      if (if0_tx_start) txq0.push_back(if0_tx_data);
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic waitTo(input int target);
      while (cyc < target) tick();
   endtask

   task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic mn);
      if0_rx_valid = v0;
      if0_rx_data  = d0;
      if1_rx_valid = v1;
      if1_rx_data  = d1;
      mode_next    = mn;
      tick();
      if0_rx_valid = 1'b0;
      if1_rx_valid = 1'b0;
      mode_next    = 1'b0;
      if0_rx_data  = 8'h00;
      if1_rx_data  = 8'h00;
   endtask

   task automatic checkQueue(input string tag, input int which, input int n, input logic [23:0] exp);
      int sz;
      logic [7:0] got;
      sz = (which == 0) ? txq0.size() : txq1.size();
      checkOutput({tag, "_count"}, sz, n);
      for (int i = 0; i < n; i++) begin
         got = 8'hEE;
         if (i < sz) got = (which == 0) ? txq0[i] : txq1[i];
         checkOutput($sformatf("%s[%0d]", tag, i), got, exp[23 - 8*i -: 8]);
      end
   endtask

   task automatic waitIdle(input string tag);
      for (int i = 0; i < 3000 && comm_active; i++) tick();
      checkOutput(tag, comm_active, 0);
   endtask

   initial begin
      sys_rst_n    = 1'b0;
      mode_next    = 1'b0;
      if0_rx_valid = 1'b0;
      if1_rx_valid = 1'b0;
      if0_rx_data  = 8'h00;
      if1_rx_data  = 8'h00;
      if0_tx_busy  = 1'b0;
      if1_tx_busy  = 1'b0;
      $display("[TB] mitm_controller test start");

      repeat (3) tick();
      checkOutput("rst_mode_leds", mode_leds, 4'b0001);
      checkOutput("rst_comm", comm_active, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_tx0_start", if0_tx_start, 0);
      checkOutput("rst_tx1_start", if1_tx_start, 0);
      checkOutput("rst_tx0_data", if0_tx_data, 0);
      checkOutput("rst_tx1_data", if1_tx_data, 0);
      checkOutput("rst_cnt0", frame_cnt0, 0);
      checkOutput("rst_cnt1", frame_cnt1, 0);
      sys_rst_n = 1'b1;
      repeat (2) tick();

      // FORWARD: latency N+2 in each direction
      applyStimulus(1'b1, 8'hCA, 1'b0, 8'h00, 1'b0);
      checkOutput("fwd_ca_start_n1", if1_tx_start, 0);
      tick();
      checkOutput("fwd_ca_start_n2", if1_tx_start, 1);
      checkOutput("fwd_ca_data", if1_tx_data, 8'hCA);
      checkOutput("fwd_ca_no_if0", if0_tx_start, 0);
      checkOutput("fwd_comm_on", comm_active, 1);
      repeat (8) tick();
      t0 = cyc;
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hF1, 1'b0);
      tick();
      checkOutput("fwd_f1_start", if0_tx_start, 1);
      checkOutput("fwd_f1_data", if0_tx_data, 8'hF1);

      // Three mode_next pulses during the session collapse into one deferred step
      waitTo(t0 + 5);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      waitTo(t0 + 20);
      checkOutput("pend_leds_hold", mode_leds, 4'b0001);
      waitTo(t0 + 1250);
      checkOutput("sess_still_on", comm_active, 1);
      tick();
      checkOutput("sess_off", comm_active, 0);
      checkOutput("pend_leds_before_step", mode_leds, 4'b0001);
      tick();
      checkOutput("pend_leds_step", mode_leds, 4'b0010);
      waitTo(t0 + 1260);
      checkOutput("pend_single_step", mode_leds, 4'b0010);

      // Mode 1: if0 substituted, if1 blocked
      txq0.delete(); txq1.delete();
      applyStimulus(1'b1, 8'h9B, 1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 8'h38, 1'b1, 8'h26, 1'b0);
      repeat (9) tick();
      checkQueue("m1_if1", 1, 2, {8'hA5, 8'hA5, 8'h00});
      checkQueue("m1_if0", 0, 0, 24'h0);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      waitIdle("m1_end");
      tick();
      checkOutput("m2_leds", mode_leds, 4'b0100);

      // Mode 2: mirror of mode 1
      txq0.delete(); txq1.delete();
      applyStimulus(1'b1, 8'hE5, 1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 8'h90, 1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hB2, 1'b0);
      repeat (9) tick();
      checkQueue("m2_if1", 1, 0, 24'h0);
      checkQueue("m2_if0", 0, 1, {8'hA5, 16'h0});
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      waitIdle("m2_end");
      tick();
      checkOutput("m3_leds", mode_leds, 4'b1000);

      // Mode 3: ROT13 on both directions simultaneously
      txq0.delete(); txq1.delete();
      applyStimulus(1'b1, 8'h61, 1'b1, 8'h61, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 8'h97, 1'b1, 8'h97, 1'b0);
      repeat (9) tick();
      checkQueue("m3_if1", 1, 3, {8'h6E, 8'h4D, 8'h97});
      checkQueue("m3_if0", 0, 3, {8'h6E, 8'h4D, 8'h97});
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      waitIdle("m3_end");
      tick();
      checkOutput("wrap_leds", mode_leds, 4'b0001);

      // rx_valid and mode_next together while idle: old mode used, step deferred
      txq0.delete(); txq1.delete();
      applyStimulus(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
      checkOutput("rxwins_leds", mode_leds, 4'b0001);
      tick();
      checkOutput("rxwins_start", if1_tx_start, 1);
      checkOutput("rxwins_data", if1_tx_data, 8'h41);
      waitIdle("rxwins_end");
      tick();
      checkOutput("rxwins_deferred", mode_leds, 4'b0010);

      // mode_next while idle steps on the next cycle
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("idle_step_a", mode_leds, 4'b0100);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("idle_step_b", mode_leds, 4'b1000);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("idle_step_c", mode_leds, 4'b0001);

      // Two forwarded frames for the frame counter
      txq0.delete(); txq1.delete();
      applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      checkQueue("cnt_if1", 1, 2, {8'h01, 8'h02, 8'h00});
      checkOutput("cnt0_two", frame_cnt0, EXP_CNT);

      // Overflow with if1 transmitter held busy
      txq1.delete();
      if1_tx_busy = 1'b1;
      applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
      repeat (3) tick();
      checkOutput("ovf_flag", overflow, 2'b01);
      checkQueue("ovf_if1", 1, 0, 24'h0);
      checkOutput("ovf_cnt0", frame_cnt0, EXP_CNT);

      // Reset mid-queue flushes everything
      sys_rst_n = 1'b0;
      #1;
      checkOutput("rst2_overflow", overflow, 0);
      checkOutput("rst2_comm", comm_active, 0);
      checkOutput("rst2_tx1_start", if1_tx_start, 0);
      checkOutput("rst2_cnt0", frame_cnt0, 0);
      tick();
      tick();
      sys_rst_n   = 1'b1;
      if1_tx_busy = 1'b0;
      repeat (20) tick();
      checkQueue("rst2_if1", 1, 0, 24'h0);
      checkOutput("rst2_overflow_after", overflow, 0);
      checkOutput("rst2_leds", mode_leds, 4'b0001);
      checkOutput("rst2_cnt0_after", frame_cnt0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mitm_controller.md
Name: mitm_controller

Overview:
- Sequences the UART man-in-the-middle datapath.
- Accepts received frames from the if0 and if1 receivers and applies the active manipulation mode. Forwards each result to the opposite interface's transmitter.
- Owns the mode register (LED display) and the communication-session tracker (activity LED).
- Sits between the per-interface rx/tx cores and the top-level button/LED logic.

Parameters:
- NUM_DATA_BITS, 8, frame payload width.
- MODE_WIDTH, 4, width of the one-hot mode output; one bit per mode.
- SUB_VALUE, 8'hA5, replacement byte used in substitute modes.
- FIFO_DEPTH, 2, entries per direction; power of two, at least 2.
- IDLE_TIMEOUT_CYCLES, 1250, idle clocks before a session is considered ended.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- mode_next  in  1  one-cycle pulse from the debounced mode button
- mode_leds  out  MODE_WIDTH  one-hot current mode
- comm_active  out  1  session in progress
- if0_rx_data  in  NUM_DATA_BITS  byte received on if0
- if0_rx_valid  in  1  one-cycle strobe, if0_rx_data valid
- if1_rx_data  in  NUM_DATA_BITS  byte received on if1
- if1_rx_valid  in  1  one-cycle strobe, if1_rx_data valid
- if0_tx_data  out  NUM_DATA_BITS  byte to transmit on if0
- if0_tx_start  out  1  one-cycle start pulse, if0 transmitter
- if0_tx_busy  in  1  if0 transmitter busy
- if1_tx_data  out  NUM_DATA_BITS  byte to transmit on if1
- if1_tx_start  out  1  one-cycle start pulse, if1 transmitter
- if1_tx_busy  in  1  if1 transmitter busy
- overflow  out  2  sticky drop flags; bit0 = if0→if1, bit1 = if1→if0
- frame_cnt0  out  16  frames forwarded if0→if1 (optional feature)
- frame_cnt1  out  16  frames forwarded if1→if0 (optional feature)

Behaviour:
- Reset (asynchronous, sys_rst_n = 0) sets:
  - mode = FORWARD, mode_leds = 4'b0001.
  - comm_active = 0, overflow = 0, both tx_start = 0, both tx_data = 0.
  - FIFOs empty, counters 0, pending-mode flag cleared.
  - Reset mid-frame discards all queued data; no tx_start is issued afterwards.
- Modes, index 0..3, wrap 3→0:
  - 0 FORWARD: both directions pass unchanged.
  - 1 SUB0_BLOCK1: if0 bytes replaced by SUB_VALUE; if1 bytes dropped (never enqueued).
  - 2 SUB1_BLOCK0: mirror of mode 1.
  - 3 ROT13: both directions; 0x41-0x5A and 0x61-0x7A rotated by 13 within their case; all other bytes unchanged.
- Transform is applied at enqueue time. The mode is sampled in the same cycle as rx_valid.
- Direction path: ifX_rx_valid enqueues into the FIFO feeding the opposite transmitter.
  - If the FIFO is full, the byte is dropped and the matching overflow bit is set.
  - The overflow bit clears only on reset.
  - Simultaneous rx_valid on both interfaces is handled independently; the two directions are fully parallel.
- Per-direction tx FSM:
  - IDLE: FIFO non-empty and tx_busy = 0 → pop, drive tx_data, pulse tx_start for 1 cycle → WAIT_BUSY.
  - WAIT_BUSY: tx_busy = 1 → WAIT_DONE. If busy is not seen within 4 cycles → IDLE; that frame counts as sent.
  - WAIT_DONE: tx_busy = 0 → IDLE.
  - tx_data holds its value until the next pop.
- Latency: rx_valid in cycle N, with the FIFO empty and the tx FSM in IDLE → tx_start high in cycle N+2.
- Session tracker:
  - Any rx_valid sets comm_active and reloads the idle counter.
  - comm_active clears when the counter reaches IDLE_TIMEOUT_CYCLES, both FIFOs are empty and both FSMs are in IDLE.
- Mode change:
  - A mode_next pulse sets the pending flag. The mode advances one step in the first cycle where comm_active = 0, then the flag clears.
  - Multiple pulses while pending collapse into one step.
  - mode_next while idle advances the mode in the next cycle.
  - mode_next in the same cycle as rx_valid while idle: rx_valid wins; the frame uses the old mode and the step is deferred.

Optional Feature:
- Macro MITM_FRAME_COUNT_EN.
- Defined: frame_cnt0/1 increment on each tx_start of their direction. They saturate at 16'hFFFF and clear on every mode change.
- Undefined: the counter logic is omitted and frame_cnt0/1 are tied to 0.

Test Plan:
- Reset, FORWARD; if0 receives 0xCA → if1_tx_data = 0xCA with tx_start at N+2. if1 0xF1 → if0 0xF1. comm_active falls 1250 cycles after the last activity.
- mode_next during an active session → mode_leds stays 0001 until comm_active = 0, then 0010. Three pulses while pending → single step.
- Mode 1: if0 0x9B → if1 receives 0xA5. Simultaneous if0 0x38 / if1 0x26 → if1 gets 0xA5, if0 gets nothing.
- Mode 2: if0 0xE5, 0x90 → nothing on if1. if1 0xB2 → if0 gets 0xA5.
- Mode 3: bytes 0x61, 0x5A, 0x97 on if0 → if1 gets 0x6E, 0x4D, 0x97. The same bytes on if1 simultaneously → same results on if0. Next mode_next → wraps to 0001.
- Hold if1_tx_busy = 1 and send three if0 bytes → third dropped, overflow = 2'b01. Assert reset mid-queue → FIFOs flushed, no tx_start. With MITM_FRAME_COUNT_EN, frame_cnt0 = 2 before reset and 0 after.
